// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
//  Bundles the three L1 request channels (I refill, D refill, D write-back)
//  and the beat-level memory port into one interface.
//  modport slave  : the arbiter's view (cache requests and memory responses in).
//  modport master : the environment's view (caches + memory bridge).
//  Cache side  : inst_ren/araddr -> inst_rvalid/rdata, data_ren/araddr -> data_rvalid/rdata,
//                data_wen/awaddr/wdata -> data_bvalid.
//  Memory side : mem_ren/rready/raddr <- mem_rdata/rvalid,
//                mem_wen/waddr/wdata/wvalid/wlast <- mem_wresp.
interface cache_mem_arbiter_if;
  logic         inst_ren_i;
  logic [31:0]  inst_araddr_i;
  logic         inst_rvalid_o;
  logic [255:0] inst_rdata_o;
  logic         data_ren_i;
  logic [31:0]  data_araddr_i;
  logic         data_rvalid_o;
  logic [255:0] data_rdata_o;
  logic         data_wen_i;
  logic [31:0]  data_awaddr_i;
  logic [255:0] data_wdata_i;
  logic         data_bvalid_o;
  logic         mem_ren_o;
  logic         mem_rready_o;
  logic [31:0]  mem_raddr_o;
  logic [31:0]  mem_rdata_i;
  logic         mem_rvalid_i;
  logic         mem_wen_o;
  logic [31:0]  mem_waddr_o;
  logic [31:0]  mem_wdata_o;
  logic         mem_wvalid_o;
  logic         mem_wlast_o;
  logic         mem_wresp_i;

  modport slave (
    input  inst_ren_i, inst_araddr_i, data_ren_i, data_araddr_i,
           data_wen_i, data_awaddr_i, data_wdata_i,
           mem_rdata_i, mem_rvalid_i, mem_wresp_i,
    output inst_rvalid_o, inst_rdata_o, data_rvalid_o, data_rdata_o, data_bvalid_o,
           mem_ren_o, mem_rready_o, mem_raddr_o,
           mem_wen_o, mem_waddr_o, mem_wdata_o, mem_wvalid_o, mem_wlast_o
  );

  modport master (
    output inst_ren_i, inst_araddr_i, data_ren_i, data_araddr_i,
           data_wen_i, data_awaddr_i, data_wdata_i,
           mem_rdata_i, mem_rvalid_i, mem_wresp_i,
    input  inst_rvalid_o, inst_rdata_o, data_rvalid_o, data_rdata_o, data_bvalid_o,
           mem_ren_o, mem_rready_o, mem_raddr_o,
           mem_wen_o, mem_waddr_o, mem_wdata_o, mem_wvalid_o, mem_wlast_o
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//  Shares one beat-level memory port between ICache refill, DCache refill and
//  DCache write-back. Read and write channels are independent FSMs that run
//  concurrently. Reads are round-robin between I and D; a D read to the line
//  currently being written back waits until that write-back finishes.
//  Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cache_mem_arbiter_if.slave (cache request channels + memory port)
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input logic               clk,
  input logic               rst,
  cache_mem_arbiter_if.slave bus
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_INST, R_DATA, R_DONE} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_DONE} wstate_t;

  rstate_t rstate, rnext;
  wstate_t wstate, wnext;

  logic [BW-1:0]                 rbeat, wbeat;
  logic [ADDR_W-1:5]             rline, wline;
  logic [LINE_WORDS-1:0][31:0]   rbuf, wbuf;
  logic                          cur_d;      // burst in flight belongs to D
  logic                          last_grant; // 0 = INST, 1 = DATA

  logic w_accept, d_block, i_elig, d_elig, grant_i, grant_d;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{bus.inst_araddr_i[4:0], bus.data_araddr_i[4:0],
                              bus.data_awaddr_i[4:0]};

  // RAW guard: a D refill must not read a line that is being (or is about to
  // be) written back, otherwise it would fetch stale memory contents.
  assign w_accept = (wstate == W_IDLE) && bus.data_wen_i;
  assign d_block  = ((wstate == W_BUSY) && (bus.data_araddr_i[ADDR_W-1:5] == wline)) ||
                    (w_accept && (bus.data_araddr_i[ADDR_W-1:5] == bus.data_awaddr_i[ADDR_W-1:5]));
  assign i_elig   = bus.inst_ren_i;
  assign d_elig   = bus.data_ren_i && !d_block;
  // On a tie the requester that was not served last wins.
  assign grant_d  = d_elig && (!i_elig || !last_grant);
  assign grant_i  = i_elig && (!d_elig ||  last_grant);

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) rstate <= R_IDLE;
    else     rstate <= rnext;
  end

  always_comb begin
    rnext             = rstate;
    bus.mem_ren_o     = 1'b0;
    bus.mem_rready_o  = 1'b0;
    bus.mem_raddr_o   = '0;
    bus.inst_rvalid_o = 1'b0;
    bus.data_rvalid_o = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (grant_d)      rnext = R_DATA;
        else if (grant_i) rnext = R_INST;
      end
      R_INST, R_DATA: begin
        bus.mem_ren_o    = 1'b1;
        bus.mem_rready_o = 1'b1;
        bus.mem_raddr_o  = {rline, rbeat, 2'b00};
        if (bus.mem_rvalid_i && rbeat == LAST_BEAT) rnext = R_DONE;
      end
      R_DONE: begin
        // Requests are ignored here so the requester has a cycle to drop ren.
        bus.inst_rvalid_o = !cur_d;
        bus.data_rvalid_o =  cur_d;
        rnext             = R_IDLE;
      end
      default: rnext = R_IDLE;
    endcase
  end

  assign bus.inst_rdata_o = bus.inst_rvalid_o ? rbuf : '0;
  assign bus.data_rdata_o = bus.data_rvalid_o ? rbuf : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rbeat      <= '0;
      rline      <= '0;
      rbuf       <= '0;
      cur_d      <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      if (rstate == R_IDLE && (grant_d || grant_i)) begin
        rline <= grant_d ? bus.data_araddr_i[ADDR_W-1:5] : bus.inst_araddr_i[ADDR_W-1:5];
        cur_d <= grant_d;
        rbeat <= '0;
      end
      if (bus.mem_rready_o && bus.mem_rvalid_i) begin
        rbuf[rbeat] <= bus.mem_rdata_i;
        if (rbeat != LAST_BEAT) rbeat <= rbeat + 1'b1;
      end
      if (rnext == R_DONE && rstate != R_DONE) last_grant <= cur_d;
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wnext;
  end

  always_comb begin
    wnext             = wstate;
    bus.mem_wen_o     = 1'b0;
    bus.mem_wvalid_o  = 1'b0;
    bus.mem_waddr_o   = '0;
    bus.mem_wdata_o   = '0;
    bus.mem_wlast_o   = 1'b0;
    bus.data_bvalid_o = 1'b0;
    case (wstate)
      W_IDLE: if (bus.data_wen_i) wnext = W_BUSY;
      W_BUSY: begin
        bus.mem_wen_o    = 1'b1;
        bus.mem_wvalid_o = 1'b1;
        bus.mem_waddr_o  = {wline, wbeat, 2'b00};
        bus.mem_wdata_o  = wbuf[wbeat];
        bus.mem_wlast_o  = (wbeat == LAST_BEAT);
        if (bus.mem_wresp_i && wbeat == LAST_BEAT) wnext = W_DONE;
      end
      W_DONE: begin
        bus.data_bvalid_o = 1'b1;
        wnext             = W_IDLE;
      end
      default: wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbeat <= '0;
      wline <= '0;
      wbuf  <= '0;
    end else begin
      if (w_accept) begin
        wline <= bus.data_awaddr_i[ADDR_W-1:5];
        wbuf  <= bus.data_wdata_i;
        wbeat <= '0;
      end else if (wstate == W_BUSY && bus.mem_wresp_i && wbeat != LAST_BEAT) begin
        wbeat <= wbeat + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_mem_arbiter_if m();
  cache_mem_arbiter dut (.clk(clk), .rst(rst), .bus(m));

  // memory model: rmode=0 -> beat index, rmode=1 -> beat address; optional stalls
  logic rmode = 1'b0, rstall = 1'b0, wstall = 1'b0, tog = 1'b0;
  always @(posedge clk) tog <= ~tog;
  assign m.mem_rvalid_i = !(rstall && tog);
  assign m.mem_rdata_i  = rmode ? m.mem_raddr_o : {29'd0, m.mem_raddr_o[4:2]};
  assign m.mem_wresp_i  = m.mem_wvalid_o && !(wstall && tog);

  // monitor (samples mid-cycle, only appends)
  int cyc = 0, ip = 0, dp = 0, bp = 0, ip_cyc = 0, dp_cyc = 0, b_cyc = 0, rise_cyc = 0;
  logic ren_q = 1'b0;
  logic [31:0] rq[$], waq[$], wdq[$];
  logic wlq[$];
  int rcq[$], wcq[$];
  logic [255:0] iline = '0, dline = '0;
  always @(negedge clk) begin
    cyc   <= cyc + 1;
    ren_q <= m.mem_ren_o;
    if (m.mem_ren_o && m.mem_rready_o && m.mem_rvalid_i) begin
      rq.push_back(m.mem_raddr_o); rcq.push_back(cyc);
    end
    if (m.mem_ren_o && !ren_q) rise_cyc <= cyc;
    if (m.inst_rvalid_o) begin ip <= ip + 1; ip_cyc <= cyc; iline <= m.inst_rdata_o; end
    if (m.data_rvalid_o) begin dp <= dp + 1; dp_cyc <= cyc; dline <= m.data_rdata_o; end
    if (m.mem_wvalid_o && m.mem_wresp_i) begin
      waq.push_back(m.mem_waddr_o); wdq.push_back(m.mem_wdata_o);
      wlq.push_back(m.mem_wlast_o); wcq.push_back(cyc);
    end
    if (m.data_bvalid_o) begin bp <= bp + 1; b_cyc <= cyc; end
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  int ip0, dp0, bp0, rb, wb;
  task automatic snap();
    ip0 = ip; dp0 = dp; bp0 = bp; rb = rq.size(); wb = waq.size();
  endtask

  // wait for the needed completions, dropping each request once it is answered
  task automatic run(input string tag, input bit ni, input bit nd, input bit nb);
    bit ok = 1'b0;
    for (int k = 0; k < 120 && !ok; k++) begin
      tick(1);
      if (ip > ip0) m.inst_ren_i = 1'b0;
      if (dp > dp0) m.data_ren_i = 1'b0;
      if (bp > bp0) m.data_wen_i = 1'b0;
      ok = (!ni || ip > ip0) && (!nd || dp > dp0) && (!nb || bp > bp0);
    end
    chk({tag, "_done"}, ok, 1);
    tick(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    m.inst_ren_i = 0; m.inst_araddr_i = 0; m.data_ren_i = 0; m.data_araddr_i = 0;
    m.data_wen_i = 0; m.data_awaddr_i = 0; m.data_wdata_i = 0;
    tick(2);
    chk("rst_ctl", {m.mem_ren_o, m.mem_rready_o, m.mem_wen_o, m.mem_wvalid_o, m.mem_wlast_o,
                    m.inst_rvalid_o, m.data_rvalid_o, m.data_bvalid_o}, 0);
    chk("rst_bus", {m.mem_raddr_o, m.mem_waddr_o, m.mem_wdata_o}, 0);
    rst = 0;
    tick(1);
    chk("idle_ctl", {m.mem_ren_o, m.mem_wen_o, m.inst_rvalid_o, m.data_rvalid_o}, 0);

    // 1: I-only refill with read stalls, beat i returns i
    snap(); rmode = 0; rstall = 1;
    m.inst_araddr_i = 32'h006C46A8; m.inst_ren_i = 1;
    run("t1", 1, 0, 0);
    rstall = 0;
    chk("t1_nbeats", rq.size() - rb, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_raddr%0d", i), rq[rb+i], 32'h006C46A0 + 4*i);
    chk("t1_line", iline,
        256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    chk("t1_pulses", ip - ip0, 1);

    // 2: simultaneous I and D after reset -> D first
    rst = 1; tick(2); rst = 0; tick(1);
    snap(); rmode = 1;
    m.inst_araddr_i = 32'h00001000; m.data_araddr_i = 32'h00002000;
    m.inst_ren_i = 1; m.data_ren_i = 1;
    run("t2", 1, 1, 0);
    chk("t2_nbeats", rq.size() - rb, 16);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_d%0d", i), rq[rb+i],   32'h00002000 + 4*i);
      chk($sformatf("t2_i%0d", i), rq[rb+8+i], 32'h00001000 + 4*i);
    end
    chk("t2_order", dp_cyc < ip_cyc, 1);
    chk("t2_ipulse", ip - ip0, 1);
    chk("t2_dpulse", dp - dp0, 1);
    chk("t2_dw0", dline[31:0], 32'h00002000);
    chk("t2_dw7", dline[255:224], 32'h0000201C);
    chk("t2_iw3", iline[127:96], 32'h0000100C);

    // 3: D arrives at I beat 4 -> no pre-emption
    snap();
    m.inst_araddr_i = 32'h00003000; m.inst_ren_i = 1;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin tick(1); ok = (rq.size() - rb >= 4); end
    chk("t3_beat4", ok, 1);
    m.data_araddr_i = 32'h00004000; m.data_ren_i = 1;
    run("t3", 1, 1, 0);
    chk("t3_i4", rq[rb+4], 32'h00003010);
    chk("t3_i7", rq[rb+7], 32'h0000301C);
    chk("t3_d0", rq[rb+8], 32'h00004000);
    chk("t3_d7", rq[rb+15], 32'h0000401C);
    chk("t3_order", ip_cyc < dp_cyc, 1);

    // 4: write-back with wresp stalls, concurrent I read
    snap(); wstall = 1;
    m.data_awaddr_i = 32'h006C46A0;
    m.data_wdata_i  = 256'h80000007_80000006_80000005_80000004_80000003_80000002_80000001_80000000;
    m.data_wen_i = 1;
    m.inst_araddr_i = 32'h00005000; m.inst_ren_i = 1;
    run("t4", 1, 0, 1);
    wstall = 0;
    chk("t4_nbeats", waq.size() - wb, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_waddr%0d", i), waq[wb+i], 32'h006C46A0 + 4*i);
      chk($sformatf("t4_wdata%0d", i), wdq[wb+i], 32'h80000000 + i);
      chk($sformatf("t4_wlast%0d", i), wlq[wb+i], i == 7);
    end
    chk("t4_bcyc", b_cyc, wcq[wb+7] + 1);
    chk("t4_bpulse", bp - bp0, 1);
    chk("t4_overlap", rcq[rb] < b_cyc, 1);
    chk("t4_ipulse", ip - ip0, 1);

    // 5a: D write and D read to same line -> read waits for bvalid
    snap();
    m.data_awaddr_i = 32'h00007000; m.data_wdata_i = '1; m.data_wen_i = 1;
    m.data_araddr_i = 32'h00007008; m.data_ren_i = 1;
    run("t5a", 0, 1, 1);
    chk("t5a_raw", rise_cyc, b_cyc + 1);
    chk("t5a_d0", rq[rb], 32'h00007000);
    chk("t5a_dpulse", dp - dp0, 1);
    // 5b: different lines run concurrently
    snap();
    m.data_awaddr_i = 32'h00008000; m.data_wen_i = 1;
    m.data_araddr_i = 32'h00009000; m.data_ren_i = 1;
    run("t5b", 0, 1, 1);
    chk("t5b_conc", rise_cyc < b_cyc, 1);
    chk("t5b_d0", rq[rb], 32'h00009000);

    // 6: reset at read beat 3
    snap();
    m.inst_araddr_i = 32'h0000A000; m.inst_ren_i = 1;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin tick(1); ok = (rq.size() - rb >= 3); end
    chk("t6_beat3", ok, 1);
    rst = 1; m.inst_ren_i = 0;
    @(posedge clk); #1;
    chk("t6_ctl", {m.mem_ren_o, m.mem_rready_o, m.inst_rvalid_o, m.data_rvalid_o}, 0);
    chk("t6_raddr", m.mem_raddr_o, 0);
    #1; rst = 0;
    tick(5);
    chk("t6_nopulse", ip - ip0, 0);
    snap();
    m.inst_araddr_i = 32'h0000B000; m.inst_ren_i = 1;
    run("t6", 1, 0, 0);
    chk("t6_restart", rq[rb], 32'h0000B000);
    chk("t6_nbeats", rq.size() - rb, 8);
    chk("t6_iw0", iline[31:0], 32'h0000B000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
